// File: rtl/sample_to_position.sv
// sample_to_position: converts a window of signed PCM samples into a 5-bit level position.
//
// Each accepted sample contributes its saturated magnitude to a running peak. After
// window_count samples the peak is normalised by left shifts, one shift per cycle, until its
// MSB reaches bit 14. The position is then 2k + b + 2, where k is the MSB index and b is the
// next bit down. A zero peak maps to position 0. The result is offered on a valid/ready
// output and held until it is taken.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high reset
//   i_valid    in   i_sample is valid
//   i_ready    out  block accepts a sample this cycle (registered, high only while accumulating)
//   i_sample   in   signed PCM sample
//   o_valid    out  o_position is valid
//   o_ready    in   downstream accepts o_position
//   o_position out  level position 0..31, holds its value after the transfer

module sample_to_position #(
    parameter int unsigned window_count = 256,
    parameter int unsigned sample_width = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic signed [sample_width-1:0] i_sample,
    output logic                           o_valid,
    input  logic                           o_ready,
    output logic [4:0]                     o_position
);

    typedef enum logic [1:0] {
        StAccum,
        StConvert,
        StOutput
    } state_e;

    localparam logic [15:0] LastIdx = 16'(window_count - 1);

    state_e      state_q;
    logic [14:0] peak_q;
    logic [15:0] count_q;
    logic [3:0]  shift_q;

    logic [15:0] mag_full;
    logic [14:0] mag;
    logic [14:0] new_peak;
    logic [3:0]  msb_idx;
    logic [4:0]  conv_pos;

    always_comb begin
        // Only -32768 leaves bit 15 set after negation; saturate it to 32767.
        mag_full = i_sample[sample_width-1] ? (~i_sample + 16'd1) : i_sample;
        mag      = mag_full[15] ? 15'h7fff : mag_full[14:0];
        new_peak = (mag > peak_q) ? mag : peak_q;
        msb_idx  = 4'd14 - shift_q;
        // The bit just below the (shifted) MSB sits at bit 13; for k = 0 it has been
        // filled by shifted-in zeros, so b = 0 falls out naturally.
        conv_pos = (peak_q == 15'd0) ? 5'd0 : ({msb_idx, peak_q[13]} + 5'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StAccum;
            i_ready    <= 1'b0;
            o_valid    <= 1'b0;
            o_position <= 5'd0;
            peak_q     <= 15'd0;
            count_q    <= 16'd0;
            shift_q    <= 4'd0;
        end else begin
            case (state_q)
                StAccum: begin
                    i_ready <= 1'b1;
                    if (i_valid && i_ready) begin
                        peak_q <= new_peak;
                        if (count_q == LastIdx) begin
                            count_q <= 16'd0;
                            i_ready <= 1'b0;
                            state_q <= StConvert;
                        end else begin
                            count_q <= count_q + 16'd1;
                        end
                    end
                end
                StConvert: begin
                    if (peak_q[14] || (shift_q == 4'd14)) begin
                        state_q    <= StOutput;
                        o_valid    <= 1'b1;
                        o_position <= conv_pos;
                    end else begin
                        peak_q  <= {peak_q[13:0], 1'b0};
                        shift_q <= shift_q + 4'd1;
                    end
                end
                StOutput: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        peak_q  <= 15'd0;
                        count_q <= 16'd0;
                        shift_q <= 4'd0;
                        state_q <= StAccum;
                        i_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StAccum;
                    i_ready <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_to_position.sv
// Directed testbench for sample_to_position with window_count = 4.
module tb_sample_to_position;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [15:0] i_sample = 16'd0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [4:0]  o_position;

    int n_cmp = 0;
    int n_bad = 0;

    sample_to_position #(
        .window_count(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_sample  (i_sample),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_position(o_position)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model used only by the back-to-back scenario.
    function automatic logic [14:0] ref_mag(input logic [15:0] s);
        int v;
        v = $signed(s);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 15'(v);
    endfunction

    function automatic logic [4:0] ref_pos(input logic [14:0] p);
        int k;
        int b;
        if (p == 15'd0) return 5'd0;
        k = 0;
        for (int j = 0; j < 15; j++) if (p[j]) k = j;
        b = (k > 0) ? int'(p[k-1]) : 0;
        return 5'(2 * k + b + 2);
    endfunction

    // Drive 4 samples (s[63:48] first), then wait for o_valid, counting CONVERT cycles.
    // Performs the output transfer if o_ready is high. Stimulus only; callers compare.
    task automatic feed_window(input logic [63:0] s, input bit keep_valid,
                               output int conv_cycles, output logic [4:0] pos,
                               output bit rdy_in_conv, output bit ok);
        bit acc;
        int budget;
        ok = 1'b1;
        conv_cycles = 0;
        pos = 5'd0;
        rdy_in_conv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_valid  = 1'b1;
            i_sample = s[63-16*i -: 16];
            budget = 0;
            acc = 1'b0;
            while (!acc && budget < 50) begin
                acc = i_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) ok = 1'b0;
        end
        if (keep_valid) i_sample = 16'd30000;
        else i_valid = 1'b0;
        budget = 0;
        while (!o_valid && budget < 40) begin
            if (i_ready) rdy_in_conv = 1'b1;
            conv_cycles++;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!o_valid) ok = 1'b0;
        pos = o_position;
        if (o_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a constant sample until n of them have been accepted.
    task automatic accept_n(input logic [15:0] s, input int n, output bit ok);
        int got;
        int budget;
        bit acc;
        got = 0;
        budget = 0;
        i_valid = 1'b1;
        i_sample = s;
        while (got < n && budget < 50) begin
            acc = i_ready;
            @(posedge clk);
            #1;
            if (acc) got++;
            budget++;
        end
        i_valid = 1'b0;
        ok = (got == n);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL reset_i_ready: got %0d expected 0", i_ready); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %0d expected 0", o_valid); end
        n_cmp++; if (o_position !== 5'd0) begin n_bad++; $display("FAIL reset_o_position: got %0d expected 0", o_position); end
        reset = 1'b0;
        #1;
        n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL release_i_ready_before_edge: got %0d expected 0", i_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL release_i_ready_after_edge: got %0d expected 1", i_ready); end
    endtask

    task automatic test_zero_window;
        int conv; logic [4:0] pos; bit rdy; bit ok;
        feed_window({16'd0, 16'd0, 16'd0, 16'd0}, 1'b0, conv, pos, rdy, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL zero_handshake: got %0d expected 1", ok); end
        n_cmp++; if (pos !== 5'd0) begin n_bad++; $display("FAIL zero_pos: got %0d expected 0", pos); end
        n_cmp++; if (conv !== 15) begin n_bad++; $display("FAIL zero_conv_cycles: got %0d expected 15", conv); end
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL zero_i_ready_in_convert: got %0d expected 0", rdy); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL zero_o_valid_after_xfer: got %0d expected 0", o_valid); end
        n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL zero_i_ready_after_xfer: got %0d expected 1", i_ready); end
    endtask

    task automatic test_peak;
        int conv; logic [4:0] pos; bit rdy; bit ok;
        // 100 = 0b1100100: k = 6, b = 1 -> 15; 8 shifts -> 9 CONVERT cycles
        feed_window({16'd100, -16'sd3, 16'd50, 16'd7}, 1'b0, conv, pos, rdy, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL peak100_handshake: got %0d expected 1", ok); end
        n_cmp++; if (pos !== 5'd15) begin n_bad++; $display("FAIL peak100_pos: got %0d expected 15", pos); end
        n_cmp++; if (conv !== 9) begin n_bad++; $display("FAIL peak100_conv_cycles: got %0d expected 9", conv); end
        n_cmp++; if (o_position !== 5'd15) begin n_bad++; $display("FAIL peak100_pos_hold: got %0d expected 15", o_position); end
    endtask

    task automatic test_boundaries;
        logic [15:0] bs [3];
        int          bp [3];
        int          bc [3];
        int conv; logic [4:0] pos; bit rdy; bit ok;
        bs = '{16'h8000, 16'd1, 16'd3};
        bp = '{31, 2, 5};
        bc = '{1, 15, 14};
        for (int i = 0; i < 3; i++) begin
            feed_window({bs[i], 16'd0, 16'd0, 16'd0}, 1'b0, conv, pos, rdy, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bound%0d_handshake: got %0d expected 1", i, ok); end
            n_cmp++; if (int'(pos) !== bp[i]) begin n_bad++; $display("FAIL bound%0d_pos: got %0d expected %0d", i, pos, bp[i]); end
            n_cmp++; if (conv !== bc[i]) begin n_bad++; $display("FAIL bound%0d_conv_cycles: got %0d expected %0d", i, conv, bc[i]); end
        end
    endtask

    task automatic test_stall;
        int conv; logic [4:0] pos; bit rdy; bit ok;
        o_ready = 1'b0;
        feed_window({16'd100, -16'sd3, 16'd50, 16'd7}, 1'b1, conv, pos, rdy, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_handshake: got %0d expected 1", ok); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL stall%0d_o_valid: got %0d expected 1", c, o_valid); end
            n_cmp++; if (o_position !== 5'd15) begin n_bad++; $display("FAIL stall%0d_pos: got %0d expected 15", c, o_position); end
            n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_i_ready: got %0d expected 0", c, i_ready); end
            @(posedge clk);
            #1;
        end
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release_o_valid: got %0d expected 0", o_valid); end
        n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_i_ready: got %0d expected 1", i_ready); end
        // A sample of 30000 leaking in during the stall would raise this window's peak.
        feed_window({16'd3, 16'd0, 16'd0, 16'd0}, 1'b0, conv, pos, rdy, ok);
        n_cmp++; if (pos !== 5'd5) begin n_bad++; $display("FAIL stall_next_pos: got %0d expected 5", pos); end
        n_cmp++; if (conv !== 14) begin n_bad++; $display("FAIL stall_next_conv_cycles: got %0d expected 14", conv); end
    endtask

    task automatic test_reset_mid;
        int conv; logic [4:0] pos; bit rdy; bit ok;
        accept_n(16'd30000, 2, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midwin_accept: got %0d expected 1", ok); end
        reset = 1'b1;
        #1;
        n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL midwin_reset_i_ready: got %0d expected 0", i_ready); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midwin_reset_o_valid: got %0d expected 0", o_valid); end
        n_cmp++; if (o_position !== 5'd0) begin n_bad++; $display("FAIL midwin_reset_pos: got %0d expected 0", o_position); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL midwin_i_ready_rise: got %0d expected 1", i_ready); end
        // 10 = 0b1010: k = 3, b = 0 -> 2*3 + 0 + 2 = 8
        feed_window({16'd10, 16'd0, 16'd0, 16'd0}, 1'b0, conv, pos, rdy, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midwin_next_handshake: got %0d expected 1", ok); end
        n_cmp++; if (pos !== 5'd8) begin n_bad++; $display("FAIL midwin_next_pos: got %0d expected 8", pos); end

        // Reset in the middle of CONVERT.
        accept_n(16'd0, 4, ok);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midconv_reset_o_valid: got %0d expected 0", o_valid); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        feed_window({16'd1, 16'd0, 16'd0, 16'd0}, 1'b0, conv, pos, rdy, ok);
        n_cmp++; if (pos !== 5'd2) begin n_bad++; $display("FAIL midconv_next_pos: got %0d expected 2", pos); end
        n_cmp++; if (conv !== 15) begin n_bad++; $display("FAIL midconv_next_conv_cycles: got %0d expected 15", conv); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] tab [12];
        logic [4:0]  exp_q [$];
        logic [14:0] peak;
        logic [4:0]  cur_pos;
        logic [4:0]  exp_pos;
        int idx, wc, acc_since, outs;
        bit acc, xfer;
        tab = '{16'd5, 16'hff38, 16'd17, 16'd0,
                16'h8000, 16'd1, 16'd2, 16'd3,
                16'd7, 16'hfff8, 16'd9, 16'hfff6};
        idx = 0; wc = 0; acc_since = 0; outs = 0; peak = 15'd0;
        o_ready = 1'b1;
        i_valid = 1'b1;
        for (int cyc = 0; cyc < 300 && outs < 3; cyc++) begin
            i_sample = (idx < 12) ? tab[idx] : 16'd0;
            acc = i_valid && i_ready;
            xfer = o_valid && o_ready;
            cur_pos = o_position;
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx < 12) begin
                    if (ref_mag(tab[idx]) > peak) peak = ref_mag(tab[idx]);
                end
                idx++;
                wc++;
                acc_since++;
                if (wc == 4) begin
                    exp_q.push_back(ref_pos(peak));
                    peak = 15'd0;
                    wc = 0;
                end
            end
            if (xfer) begin
                exp_pos = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
                n_cmp++; if (cur_pos !== exp_pos) begin n_bad++; $display("FAIL b2b%0d_pos: got %0d expected %0d", outs, cur_pos, exp_pos); end
                n_cmp++; if (acc_since !== 4) begin n_bad++; $display("FAIL b2b%0d_samples_per_output: got %0d expected 4", outs, acc_since); end
                acc_since = 0;
                outs++;
            end
        end
        i_valid = 1'b0;
        n_cmp++; if (outs !== 3) begin n_bad++; $display("FAIL b2b_output_count: got %0d expected 3", outs); end
    endtask

    initial begin
        test_reset();
        test_zero_window();
        test_peak();
        test_boundaries();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
